// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared constants for the ROM arbiter.
//   - ROM access op codes driven by the memory stage (NOP/READ/WRITE)
//   - arbiter state codes (IDLE/BUSY)
//   - access owner codes (IF/MEM)
//   - helpers: op decode, wait-counter width
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    PC_ROM_OP_NOP   = 2'b00,
    PC_ROM_OP_READ  = 2'b01,
    PC_ROM_OP_WRITE = 2'b10
  } rom_op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IF  = 1'b0,
    ARB_OWNER_MEM = 1'b1
  } arb_owner_e;

  // Only READ and WRITE request the ROM; the spare encoding behaves as NOP.
  function automatic logic op_is_access(input logic [1:0] op);
    return (op == PC_ROM_OP_READ) || (op == PC_ROM_OP_WRITE);
  endfunction

  // Counter must hold WAIT-1; keep at least one bit so WAIT=1 still builds.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: down-counter holding the remaining ROM wait cycles.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (takes precedence over dec)
//   load_val  - value loaded on a grant (WAIT-1)
//   dec       - decrement by one; holds at zero
//   zero      - counter is zero (final cycle of a BUSY access)
module arb_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one ROM between instruction fetch (IF) and the
// load/store port (MEM). Data accesses win over fetches in IDLE; an access
// in progress is never preempted. Each access keeps the ROM busy for WAIT
// cycles, followed by one IDLE cycle.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   flush                     - aborts an in-flight fetch (MEM unaffected)
//   if_req_i, if_addr_i       - fetch request / address
//   if_inst_o, if_ack_o       - fetched instruction (held), completion pulse
//   mem_op_i, mem_addr_i,
//   mem_wdata_i               - data op (NOP/READ/WRITE), address, store data
//   mem_rdata_o, mem_ack_o    - load data (held), completion pulse
//   rom_ce_o, rom_we_o,
//   rom_addr_o, rom_wdata_o   - ROM control, address, write data
//   rom_rdata_i               - ROM read data, valid in the final cycle
//   stallreq_o                - a pending request is not acked this cycle
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_ack_o,
  input  logic [1:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              rom_ce_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [DATA_W-1:0] rom_wdata_o,
  input  logic [DATA_W-1:0] rom_rdata_i,
  output logic              stallreq_o
);

  localparam int               CNT_W    = cnt_width(WAIT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              wr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] rom_wdata_q;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic mem_req;
  logic grant;
  logic busy;
  logic cnt_zero;
  logic final_cyc;
  logic abort;

  assign mem_req   = op_is_access(mem_op_i);
  assign busy      = (state_q == ARB_BUSY);
  assign final_cyc = busy && cnt_zero;
  // A flush only kills fetches; stores must never be torn.
  assign abort     = busy && (owner_q == ARB_OWNER_IF) && flush;

  arb_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (LOAD_VAL),
    .dec      (busy),
    .zero     (cnt_zero)
  );

  // Next-state / grant decision
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant   = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (mem_req) begin
        grant   = 1'b1;
        owner_d = ARB_OWNER_MEM;
        state_d = ARB_BUSY;
      end else if (if_req_i) begin
        grant   = 1'b1;
        owner_d = ARB_OWNER_IF;
        state_d = ARB_BUSY;
      end
    end else if (abort || cnt_zero) begin
      state_d = ARB_IDLE;
    end
  end

  // State, ROM output registers and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWNER_IF;
      wr_q        <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (grant) begin
        if (owner_d == ARB_OWNER_MEM) begin
          wr_q        <= (mem_op_i == PC_ROM_OP_WRITE);
          rom_addr_q  <= mem_addr_i;
          rom_wdata_q <= mem_wdata_i;
        end else begin
          wr_q       <= 1'b0;
          rom_addr_q <= if_addr_i;
        end
      end
      if (if_ack_o) begin
        if_inst_q <= rom_rdata_i;
      end
      if (mem_ack_o && !wr_q) begin
        mem_rdata_q <= rom_rdata_i;
      end
    end
  end

  assign rom_ce_o    = busy;
  assign rom_we_o    = busy && (owner_q == ARB_OWNER_MEM) && wr_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_wdata_o = rom_wdata_q;

  assign if_ack_o  = final_cyc && (owner_q == ARB_OWNER_IF) && !flush;
  assign mem_ack_o = final_cyc && (owner_q == ARB_OWNER_MEM);

  // Read data is forwarded in the ack cycle and held afterwards.
  assign if_inst_o   = if_ack_o ? rom_rdata_i : if_inst_q;
  assign mem_rdata_o = (mem_ack_o && !wr_q) ? rom_rdata_i : mem_rdata_q;

  assign stallreq_o = (if_req_i && !if_ack_o) || (mem_req && !mem_ack_o);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed test of rom_arbiter. Instance a uses WAIT=2,
// instance b uses WAIT=3 and has its own reset; both share all other inputs.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_b = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [1:0]  mem_op = 2'b00;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic [31:0] a_if_inst, a_mem_rdata, a_rom_addr, a_rom_wdata, a_rom_rdata;
  logic        a_if_ack, a_mem_ack, a_rom_ce, a_rom_we, a_stall;
  logic [31:0] b_if_inst, b_mem_rdata, b_rom_addr, b_rom_wdata, b_rom_rdata;
  logic        b_if_ack, b_mem_ack, b_rom_ce, b_rom_we, b_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h3C01_0001;
      32'h0000_0104: return 32'h27BD_FFF0;
      32'h0000_2000: return 32'hDEAD_BEEF;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign a_rom_rdata = rom_model(a_rom_addr);
  assign b_rom_rdata = rom_model(b_rom_addr);

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(a_if_inst), .if_ack_o(a_if_ack),
    .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(a_mem_rdata), .mem_ack_o(a_mem_ack),
    .rom_ce_o(a_rom_ce), .rom_we_o(a_rom_we), .rom_addr_o(a_rom_addr),
    .rom_wdata_o(a_rom_wdata), .rom_rdata_i(a_rom_rdata), .stallreq_o(a_stall)
  );

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(3)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(b_if_inst), .if_ack_o(b_if_ack),
    .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(b_mem_rdata), .mem_ack_o(b_mem_ack),
    .rom_ce_o(b_rom_ce), .rom_we_o(b_rom_we), .rom_addr_o(b_rom_addr),
    .rom_wdata_o(b_rom_wdata), .rom_rdata_i(b_rom_rdata), .stallreq_o(b_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    tick(); tick();
    rst = 1'b0; rst_b = 1'b0;
    #1;
    check("rst_ce", a_rom_ce, 0);
    check("rst_we", a_rom_we, 0);
    check("rst_addr", a_rom_addr, 0);
    check("rst_wdata", a_rom_wdata, 0);
    check("rst_inst", a_if_inst, 0);
    check("rst_rdata", a_mem_rdata, 0);
    check("rst_if_ack", a_if_ack, 0);
    check("rst_mem_ack", a_mem_ack, 0);
    check("rst_stall", a_stall, 0);

    // fetch only: T
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("f_T_stall", a_stall, 1);
    check("f_T_ce", a_rom_ce, 0);
    tick(); // T+1
    check("f_T1_ce", a_rom_ce, 1);
    check("f_T1_addr", a_rom_addr, 32'h100);
    check("f_T1_ack", a_if_ack, 0);
    check("f_T1_stall", a_stall, 1);
    tick(); // T+2
    check("f_T2_ce", a_rom_ce, 1);
    check("f_T2_ack", a_if_ack, 1);
    check("f_T2_inst", a_if_inst, 32'h3C01_0001);
    check("f_T2_stall", a_stall, 0);
    tick(); // T+3
    if_req = 1'b0;
    #1;
    check("f_T3_ce", a_rom_ce, 0);
    check("f_T3_ack", a_if_ack, 0);
    check("f_T3_inst_hold", a_if_inst, 32'h3C01_0001);

    // simultaneous fetch + MEM read
    tick(); // T
    if_req = 1'b1; if_addr = 32'h104;
    mem_op = 2'b01; mem_addr = 32'h2000;
    #1;
    check("s_T_stall", a_stall, 1);
    tick(); // T+1
    check("s_T1_ce", a_rom_ce, 1);
    check("s_T1_addr", a_rom_addr, 32'h2000);
    check("s_T1_we", a_rom_we, 0);
    tick(); // T+2
    check("s_T2_mem_ack", a_mem_ack, 1);
    check("s_T2_rdata", a_mem_rdata, 32'hDEAD_BEEF);
    check("s_T2_if_ack", a_if_ack, 0);
    check("s_T2_stall", a_stall, 1);
    tick(); // T+3
    mem_op = 2'b00;
    #1;
    check("s_T3_ce", a_rom_ce, 0);
    check("s_T3_rdata_hold", a_mem_rdata, 32'hDEAD_BEEF);
    check("s_T3_stall", a_stall, 1);
    tick(); // T+4
    check("s_T4_ce", a_rom_ce, 1);
    check("s_T4_addr", a_rom_addr, 32'h104);
    check("s_T4_if_ack", a_if_ack, 0);
    check("s_T4_stall", a_stall, 1);
    tick(); // T+5
    check("s_T5_if_ack", a_if_ack, 1);
    check("s_T5_inst", a_if_inst, 32'h27BD_FFF0);
    check("s_T5_stall", a_stall, 0);
    tick();
    if_req = 1'b0;

    // MEM write
    tick(); // T
    mem_op = 2'b10; mem_addr = 32'h2004; mem_wdata = 32'h1234_5678;
    #1;
    check("w_T_we", a_rom_we, 0);
    tick(); // T+1
    check("w_T1_we", a_rom_we, 1);
    check("w_T1_addr", a_rom_addr, 32'h2004);
    check("w_T1_wdata", a_rom_wdata, 32'h1234_5678);
    check("w_T1_ack", a_mem_ack, 0);
    tick(); // T+2
    check("w_T2_we", a_rom_we, 1);
    check("w_T2_ack", a_mem_ack, 1);
    check("w_T2_rdata_keep", a_mem_rdata, 32'hDEAD_BEEF);
    check("w_T2_inst_keep", a_if_inst, 32'h27BD_FFF0);
    tick(); // T+3
    mem_op = 2'b00;
    #1;
    check("w_T3_we", a_rom_we, 0);
    check("w_T3_ce", a_rom_ce, 0);

    // flush in first BUSY cycle of a fetch
    tick(); // T
    if_req = 1'b1; if_addr = 32'h108;
    tick(); // T+1
    flush = 1'b1;
    #1;
    check("fl_T1_ce", a_rom_ce, 1);
    check("fl_T1_ack", a_if_ack, 0);
    tick(); // T+2
    flush = 1'b0; if_addr = 32'h200;
    #1;
    check("fl_T2_ce", a_rom_ce, 0);
    check("fl_T2_ack", a_if_ack, 0);
    check("fl_T2_inst", a_if_inst, 32'h27BD_FFF0);
    tick(); // T+3
    check("fl_T3_ce", a_rom_ce, 1);
    check("fl_T3_addr", a_rom_addr, 32'h200);
    tick(); // T+4
    check("fl_T4_ack", a_if_ack, 1);
    check("fl_T4_inst", a_if_inst, 32'hA5A5_0200);
    tick();
    if_req = 1'b0;

    // flush during the final cycle of a fetch suppresses the ack
    tick(); // T
    if_req = 1'b1; if_addr = 32'h100;
    tick(); // T+1
    tick(); // T+2
    flush = 1'b1;
    #1;
    check("ff_T2_ack", a_if_ack, 0);
    check("ff_T2_inst", a_if_inst, 32'hA5A5_0200);
    check("ff_T2_stall", a_stall, 1);
    tick(); // T+3
    flush = 1'b0; if_req = 1'b0;
    #1;
    check("ff_T3_ce", a_rom_ce, 0);
    check("ff_T3_inst", a_if_inst, 32'hA5A5_0200);

    // flush during a MEM write has no effect
    tick(); // T
    mem_op = 2'b10; mem_addr = 32'h2008; mem_wdata = 32'hCAFE_F00D;
    tick(); // T+1
    flush = 1'b1;
    #1;
    check("fw_T1_we", a_rom_we, 1);
    tick(); // T+2
    check("fw_T2_we", a_rom_we, 1);
    check("fw_T2_ack", a_mem_ack, 1);
    check("fw_T2_wdata", a_rom_wdata, 32'hCAFE_F00D);
    tick(); // T+3
    flush = 1'b0; mem_op = 2'b00;
    #1;
    check("fw_T3_ce", a_rom_ce, 0);

    // unknown op encoding behaves as NOP
    tick();
    mem_op = 2'b11; mem_addr = 32'h3000;
    #1;
    check("op3_stall", a_stall, 0);
    tick();
    check("op3_ce", a_rom_ce, 0);
    mem_op = 2'b00;

    // let instance b drain before its reset test
    repeat (6) tick();

    // rst mid-access on WAIT=3 instance
    if_req = 1'b1; if_addr = 32'h100; // T
    tick(); // T+1
    check("r_T1_ce", b_rom_ce, 1);
    tick(); // T+2
    rst_b = 1'b1;
    #1;
    check("r_T2_ack", b_if_ack, 0);
    tick(); // T+3
    rst_b = 1'b0; if_req = 1'b0;
    #1;
    check("r_ce", b_rom_ce, 0);
    check("r_we", b_rom_we, 0);
    check("r_addr", b_rom_addr, 0);
    check("r_wdata", b_rom_wdata, 0);
    check("r_inst", b_if_inst, 0);
    check("r_rdata", b_mem_rdata, 0);
    check("r_if_ack", b_if_ack, 0);
    check("r_mem_ack", b_mem_ack, 0);
    check("r_stall", b_stall, 0);

    // request after reset completes with WAIT=3 latency
    tick(); // T
    mem_op = 2'b01; mem_addr = 32'h2000;
    #1;
    check("b_T_stall", b_stall, 1);
    tick(); // T+1
    check("b_T1_ce", b_rom_ce, 1);
    tick(); // T+2
    check("b_T2_ack", b_mem_ack, 0);
    check("b_T2_stall", b_stall, 1);
    tick(); // T+3
    check("b_T3_ack", b_mem_ack, 1);
    check("b_T3_rdata", b_mem_rdata, 32'hDEAD_BEEF);
    check("b_T3_stall", b_stall, 0);
    tick();
    mem_op = 2'b00;
    #1;
    check("b_T4_ce", b_rom_ce, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
